// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framer: start detect, 3-sample majority vote, LSB-first
// deserializer, parity-check handoff and per-frame result pulses.
module uart_rx_frame_ctrl #(
  parameter int PRESCALE = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       par_err,
  output logic [7:0] data_bits,
  output logic       par_bit,
  output logic       par_chk_en,
  output logic [7:0] P_DATA,
  output logic       data_valid,
  output logic       par_err_out,
  output logic       stp_err,
  output logic       strt_glitch,
  output logic       busy
);

  localparam int EW = $clog2(PRESCALE);
  localparam int M  = PRESCALE / 2;
  localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] E_S0   = EW'(M - 1);
  localparam logic [EW-1:0] E_S1   = EW'(M);
  localparam logic [EW-1:0] E_S2   = EW'(M + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] edge_q, edge_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    smp_q, smp_d;
  logic          par_en_q, par_en_d;
  logic [7:0]    data_bits_q, data_bits_d;
  logic          par_bit_q, par_bit_d;
  logic [7:0]    p_data_q, p_data_d;
  logic          dv_q, dv_d;
  logic          pe_q, pe_d;
  logic          se_q, se_d;
  logic          sg_q, sg_d;
  logic          bit_end;
  logic          voted;

  assign bit_end = (edge_q == E_LAST);
  assign voted   = (smp_q[0] & smp_q[1]) |
                   (smp_q[1] & smp_q[2]) |
                   (smp_q[0] & smp_q[2]);

  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q;
    bit_d       = bit_q;
    smp_d       = smp_q;
    par_en_d    = par_en_q;
    data_bits_d = data_bits_q;
    par_bit_d   = par_bit_q;
    p_data_d    = p_data_q;
    dv_d        = 1'b0;
    pe_d        = 1'b0;
    se_d        = 1'b0;
    sg_d        = 1'b0;

    if (state_q == IDLE) begin
      edge_d = RX_IN ? '0 : EW'(1);
    end else begin
      edge_d = bit_end ? '0 : edge_q + EW'(1);
      if (edge_q == E_S0) smp_d[0] = RX_IN;
      if (edge_q == E_S1) smp_d[1] = RX_IN;
      if (edge_q == E_S2) smp_d[2] = RX_IN;
    end

    unique case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d  = START;
          par_en_d = PAR_EN;
        end
      end
      START: begin
        if (bit_end) begin
          if (voted) begin
            sg_d    = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          data_bits_d = {voted, data_bits_q[7:1]};
          bit_d       = bit_q + 3'd1;
          if (bit_q == 3'd7)
            state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_bit_d = voted;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!voted) begin
            se_d = 1'b1;
          end else if (par_err && par_en_q) begin
            pe_d = 1'b1;
          end else begin
            dv_d     = 1'b1;
            p_data_d = data_bits_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      edge_q      <= '0;
      bit_q       <= '0;
      smp_q       <= '0;
      par_en_q    <= 1'b0;
      data_bits_q <= '0;
      par_bit_q   <= 1'b0;
      p_data_q    <= '0;
      dv_q        <= 1'b0;
      pe_q        <= 1'b0;
      se_q        <= 1'b0;
      sg_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      bit_q       <= bit_d;
      smp_q       <= smp_d;
      par_en_q    <= par_en_d;
      data_bits_q <= data_bits_d;
      par_bit_q   <= par_bit_d;
      p_data_q    <= p_data_d;
      dv_q        <= dv_d;
      pe_q        <= pe_d;
      se_q        <= se_d;
      sg_q        <= sg_d;
    end
  end

  assign data_bits   = data_bits_q;
  assign par_bit     = par_bit_q;
  assign par_chk_en  = (state_q == STOP) && par_en_q;
  assign P_DATA      = p_data_q;
  assign data_valid  = dv_q;
  assign par_err_out = pe_q;
  assign stp_err     = se_q;
  assign strt_glitch = sg_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a behavioural parity checker.
// Line waveforms are built per cycle; cycle 0 is the start-detect cycle.
module tb_uart_rx_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       par_err;
  logic [7:0] data_bits;
  logic       par_bit;
  logic       par_chk_en;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err_out;
  logic       stp_err;
  logic       strt_glitch;
  logic       busy;
  logic       odd_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  logic line [0:255];
  int dv_n, dv_first, dv_last, pe_n, pe_cyc;
  int se_n, se_cyc, sg_n, sg_cyc, pce_n;
  logic busy1, busy_end;
  logic [22:0] snap;

  always #5 CLK = ~CLK;

  assign par_err = par_chk_en & (^{data_bits, par_bit} ^ odd_mode);

  uart_rx_frame_ctrl #(.PRESCALE(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
    .par_err(par_err), .data_bits(data_bits), .par_bit(par_bit),
    .par_chk_en(par_chk_en), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err_out(par_err_out), .stp_err(stp_err),
    .strt_glitch(strt_glitch), .busy(busy)
  );

  task automatic clear_line();
    for (int i = 0; i < 256; i++) line[i] = 1'b1;
  endtask

  task automatic put_frame(input int at, input logic [7:0] b,
                           input logic pe, input logic pb,
                           input logic sb);
    logic v;
    int nb;
    nb = pe ? 11 : 10;
    for (int j = 0; j < nb; j++) begin
      if (j == 0) v = 1'b0;
      else if (j <= 8) v = b[j-1];
      else if (pe && j == 9) v = pb;
      else v = sb;
      for (int c = 0; c < 8; c++) line[at + j*8 + c] = v;
    end
  endtask

  task automatic run(input int n, input int rst_at);
    dv_n = 0; dv_first = -1; dv_last = -1;
    pe_n = 0; pe_cyc = -1; se_n = 0; se_cyc = -1;
    sg_n = 0; sg_cyc = -1; pce_n = 0;
    busy1 = 1'b0; busy_end = 1'b1; snap = '1;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (data_valid) begin
        dv_n++;
        if (dv_first < 0) dv_first = i;
        dv_last = i;
      end
      if (par_err_out) begin pe_n++; pe_cyc = i; end
      if (stp_err) begin se_n++; se_cyc = i; end
      if (strt_glitch) begin sg_n++; sg_cyc = i; end
      if (par_chk_en) pce_n++;
      if (i == 1) busy1 = busy;
      if (i == rst_at + 1)
        snap = {data_bits, par_bit, par_chk_en, P_DATA, data_valid,
                par_err_out, stp_err, strt_glitch, busy};
      busy_end = busy;
      RST = (i == rst_at);
      RX_IN = line[i];
    end
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({data_bits, par_bit, par_chk_en, P_DATA, data_valid, par_err_out,
         stp_err, strt_glitch, busy} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got db=%h P=%h busy=%b exp all 0",
               data_bits, P_DATA, busy);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_no_parity();
    PAR_EN = 1'b0;
    clear_line();
    put_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    run(100, -1);
    checks++;
    if (dv_n !== 1 || dv_first !== 80) begin
      errors++;
      $display("FAIL np_dv got n=%0d cyc=%0d exp n=1 cyc=80", dv_n, dv_first);
    end
    checks++;
    if (P_DATA !== 8'hA5 || data_bits !== 8'hA5) begin
      errors++;
      $display("FAIL np_data got P=%h db=%h exp a5", P_DATA, data_bits);
    end
    checks++;
    if (pe_n + se_n + sg_n + pce_n !== 0) begin
      errors++;
      $display("FAIL np_err got pe=%0d se=%0d sg=%0d pce=%0d exp 0",
               pe_n, se_n, sg_n, pce_n);
    end
    checks++;
    if (busy1 !== 1'b1 || busy_end !== 1'b0) begin
      errors++;
      $display("FAIL np_busy got %b/%b exp 1/0", busy1, busy_end);
    end
  endtask

  task automatic test_parity();
    PAR_EN = 1'b1;
    clear_line();
    put_frame(0, 8'h3C, 1'b1, 1'b0, 1'b1);
    run(100, -1);
    checks++;
    if (dv_n !== 1 || dv_first !== 88 || P_DATA !== 8'h3C) begin
      errors++;
      $display("FAIL par_ok got n=%0d cyc=%0d P=%h exp 1 88 3c",
               dv_n, dv_first, P_DATA);
    end
    checks++;
    if (pce_n !== 8 || pe_n !== 0) begin
      errors++;
      $display("FAIL par_win got pce=%0d pe=%0d exp 8 0", pce_n, pe_n);
    end
    clear_line();
    put_frame(0, 8'h3C, 1'b1, 1'b1, 1'b1);
    run(100, -1);
    checks++;
    if (pe_n !== 1 || pe_cyc !== 88 || dv_n !== 0 || se_n !== 0) begin
      errors++;
      $display("FAIL par_bad got pe=%0d cyc=%0d dv=%0d se=%0d exp 1 88 0 0",
               pe_n, pe_cyc, dv_n, se_n);
    end
    checks++;
    if (P_DATA !== 8'h3C || par_bit !== 1'b1) begin
      errors++;
      $display("FAIL par_hold got P=%h pb=%b exp 3c 1", P_DATA, par_bit);
    end
    PAR_EN = 1'b0;
  endtask

  task automatic test_start_glitch();
    clear_line();
    line[0] = 1'b0; line[1] = 1'b0; line[2] = 1'b0;
    run(30, -1);
    checks++;
    if (sg_n !== 1 || sg_cyc !== 8 || dv_n !== 0) begin
      errors++;
      $display("FAIL glitch got n=%0d cyc=%0d dv=%0d exp 1 8 0",
               sg_n, sg_cyc, dv_n);
    end
    checks++;
    if (busy1 !== 1'b1 || busy_end !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy got %b/%b exp 1/0", busy1, busy_end);
    end
  endtask

  task automatic test_stop_err();
    clear_line();
    put_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
    run(100, -1);
    checks++;
    if (se_n !== 1 || se_cyc !== 80 || dv_n !== 0 || pe_n !== 0) begin
      errors++;
      $display("FAIL stop_err got n=%0d cyc=%0d dv=%0d exp 1 80 0",
               se_n, se_cyc, dv_n);
    end
  endtask

  task automatic test_vote();
    clear_line();
    put_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    line[36] = 1'b1;
    run(100, -1);
    checks++;
    if (dv_n !== 1 || P_DATA !== 8'h55) begin
      errors++;
      $display("FAIL vote_mask got n=%0d P=%h exp 1 55", dv_n, P_DATA);
    end
    clear_line();
    put_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    line[35] = 1'b1; line[36] = 1'b1; line[37] = 1'b1;
    run(100, -1);
    checks++;
    if (dv_n !== 1 || P_DATA !== 8'h5D) begin
      errors++;
      $display("FAIL vote_flip got n=%0d P=%h exp 1 5d", dv_n, P_DATA);
    end
  endtask

  task automatic test_back_to_back();
    clear_line();
    put_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    for (int i = 40; i < 100; i++) line[i] = 1'b1;
    run(100, 40);
    checks++;
    if (snap !== 23'd0) begin
      errors++;
      $display("FAIL midrst_outputs got %h exp 0", snap);
    end
    checks++;
    if (dv_n + pe_n + se_n + sg_n !== 0 || busy_end !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pulses got %0d busy=%b exp 0 0",
               dv_n + pe_n + se_n + sg_n, busy_end);
    end
    clear_line();
    put_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
    put_frame(80, 8'h34, 1'b0, 1'b0, 1'b1);
    run(180, -1);
    checks++;
    if (dv_n !== 2 || dv_first !== 80 || dv_last !== 160) begin
      errors++;
      $display("FAIL b2b_dv got n=%0d first=%0d last=%0d exp 2 80 160",
               dv_n, dv_first, dv_last);
    end
    checks++;
    if (P_DATA !== 8'h34 || se_n + sg_n !== 0) begin
      errors++;
      $display("FAIL b2b_data got P=%h errs=%0d exp 34 0",
               P_DATA, se_n + sg_n);
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_start_glitch();
    test_stop_err();
    test_vote();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
